// File: rtl/router_pkg.sv
// Shared router types and header layout.
// Used by the packet reader and writer paths.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  // header byte = {len, addr}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } rd_state_e;

endpackage

// File: rtl/router_pkt_reader.sv
// Output-port packet reader: drains the FIFO, frames packets.
// Parity check built only with ROUTER_PKT_READER_PARITY_CHK_EN.
module router_pkt_reader #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              r_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              busy
);

  import router_pkg::*;

  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic              rd_q;
  logic [LEN_W:0]    rem_q;
  logic [LEN_W:0]    rem_ld;
  logic [LEN_W-1:0]  hdr_len;
  logic              r_en_c;

  assign hdr_len = dout[HDR_LEN_LSB +: LEN_W];

  // reads still owed after the header: payload plus parity
  always_comb begin
    rem_ld = {1'b0, hdr_len} + REM_ONE;
    if (hdr_len == '0) begin
      rem_ld = REM_ONE + REM_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_en_c    = 1'b0;
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
    pkt_done  = 1'b0;
    pkt_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (!soft_rst && !empty && out_ready) begin
          r_en_c  = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (soft_rst) begin
          state_d = IDLE;
        end else begin
          pkt_valid = 1'b1;
          pkt_sop   = 1'b1;
          pkt_data  = dout;
          state_d   = BODY;
        end
      end
      BODY: begin
        if (soft_rst) begin
          state_d = IDLE;
        end else begin
          r_en_c = !empty && out_ready
                   && (rem_q != '0);
          if (rd_q) begin
            pkt_valid = 1'b1;
            pkt_data  = dout;
            if (rem_q == '0) begin
              pkt_eop  = 1'b1;
              pkt_done = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // keep the FIFO untouched while reset is held
  assign r_en = r_en_c & rst;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      rem_q    <= '0;
      pkt_len  <= '0;
      pkt_addr <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= (state_q == BODY) && r_en_c;
      if (state_q == HDR && !soft_rst) begin
        pkt_len  <= hdr_len;
        pkt_addr <= dout[HDR_ADDR_LSB +: ADDR_W];
        rem_q    <= rem_ld;
      end else if (state_q == BODY && r_en_c) begin
        rem_q <= rem_q - REM_ONE;
      end
    end
  end

`ifdef ROUTER_PKT_READER_PARITY_CHK_EN
  logic [DATA_W-1:0] acc_q;
  logic              perr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      if (state_q == HDR) begin
        acc_q <= dout;
      end else if (rd_q && rem_q != '0) begin
        acc_q <= acc_q ^ dout;
      end
      if (pkt_done) begin
        perr_q <= (acc_q != dout);
      end
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
